// File: rtl/mul_periph_pkg.sv
// Shared constants and types for the memory-mapped multiplier peripheral.
// Optional feature macro: MUL_PERIPH_HI_EN (upper product word at offset 4).
package mul_periph_pkg;

   localparam int W_DEF = 16;

   localparam logic [2:0] OFF_OPA    = 3'd0;
   localparam logic [2:0] OFF_OPB    = 3'd1;
   localparam logic [2:0] OFF_CTRL   = 3'd2;
   localparam logic [2:0] OFF_RES    = 3'd3;
   localparam logic [2:0] OFF_RES_HI = 3'd4;

   localparam int CTRL_START = 0;
   localparam int CTRL_CLEAR = 1;
   localparam int STAT_BUSY  = 0;
   localparam int STAT_DONE  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mul_core.sv
// Shift-add multiply engine: one multiplier bit per cycle, LSB first.
// With MUL_PERIPH_HI_EN it builds the full 2W-bit signed product (one extra cycle).
module mul_core
   import mul_periph_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         clear_done,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   output logic [W-1:0] result,
   output logic [W-1:0] result_hi,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(W);

   state_t        state;
   logic [CW-1:0] count;
   logic          accept;
   logic          last;

   assign accept = start && (state != RUN);
   assign last   = (count == CW'(W - 1));

`ifdef MUL_PERIPH_HI_EN
   logic [2*W-1:0] mcand_p0;
   logic [2*W-1:0] acc_p0;
   logic [2*W-1:0] acc_next;
   logic [2*W-1:0] prod;
   logic [W-1:0]   mplier_p0;
   logic           neg_p0;
   logic           fin;

   function automatic logic [W-1:0] mag(input logic [W-1:0] v);
      return v[W-1] ? -v : v;
   endfunction

   assign acc_next = mplier_p0[0] ? (acc_p0 + mcand_p0) : acc_p0;
   assign prod     = neg_p0 ? -acc_p0 : acc_p0;

   // p0: magnitude shadows and 2W-bit accumulator
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand_p0  <= {{W{1'b0}}, mag(opa)};
         mplier_p0 <= mag(opb);
         acc_p0    <= '0;
         neg_p0    <= opa[W-1] ^ opb[W-1];
      end else if (state == RUN && !fin) begin
         acc_p0    <= acc_next;
         mcand_p0  <= mcand_p0 << 1;
         mplier_p0 <= mplier_p0 >> 1;
      end
   end
`else
   logic [W-1:0] mcand_p0;
   logic [W-1:0] mplier_p0;
   logic [W-1:0] acc_p0;
   logic [W-1:0] acc_next;

   // Low W bits of a two's-complement product do not depend on signedness.
   assign acc_next  = mplier_p0[0] ? (acc_p0 + mcand_p0) : acc_p0;
   assign result_hi = '0;

   // p0: operand shadows and accumulator
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand_p0  <= opa;
         mplier_p0 <= opb;
         acc_p0    <= '0;
      end else if (state == RUN) begin
         acc_p0    <= acc_next;
         mcand_p0  <= mcand_p0 << 1;
         mplier_p0 <= mplier_p0 >> 1;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
`ifdef MUL_PERIPH_HI_EN
         result_hi <= '0;
         fin       <= 1'b0;
`endif
      end else begin
         case (state)
            RUN: begin
`ifdef MUL_PERIPH_HI_EN
               if (fin) begin
                  result    <= prod[W-1:0];
                  result_hi <= prod[2*W-1:W];
                  fin       <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  count <= count + CW'(1);
                  fin   <= last;
               end
`else
               count <= count + CW'(1);
               if (last) begin
                  result <= acc_next;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
`endif
            end
            default: begin
               // start takes priority over clear_done when both are written
               if (accept) begin
                  state <= RUN;
                  count <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end else if (clear_done) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/mul_periph.sv
// Bus-facing wrapper: address decode, OPA/OPB registers, read mux and irq.
// Optional feature macro: MUL_PERIPH_HI_EN (handled inside mul_core).
module mul_periph
   import mul_periph_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h6100,
   parameter int          W         = W_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [15:0]  addrM,
   input  logic [W-1:0] outM,
   input  logic         writeM,
   output logic [W-1:0] rdata,
   output logic         sel,
   output logic         irq
);

   logic [2:0]   off;
   logic         wr;
   logic         start;
   logic         clear_done;
   logic [W-1:0] opa;
   logic [W-1:0] opb;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         busy;
   logic         done;

   assign sel        = (addrM[15:3] == BASE_ADDR[15:3]);
   assign off        = addrM[2:0];
   assign wr         = sel && writeM;
   assign start      = wr && (off == OFF_CTRL) && outM[CTRL_START];
   assign clear_done = wr && (off == OFF_CTRL) && outM[CTRL_CLEAR];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         opa <= '0;
         opb <= '0;
         irq <= 1'b0;
      end else begin
         if (wr && off == OFF_OPA) opa <= outM;
         if (wr && off == OFF_OPB) opb <= outM;
         irq <= done;
      end
   end

   mul_core #(.W(W)) u_core (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .clear_done (clear_done),
      .opa        (opa),
      .opb        (opb),
      .result     (result),
      .result_hi  (result_hi),
      .busy       (busy),
      .done       (done)
   );

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (off)
            OFF_OPA:    rdata = opa;
            OFF_OPB:    rdata = opb;
            OFF_CTRL: begin
               rdata[STAT_BUSY] = busy;
               rdata[STAT_DONE] = done;
            end
            OFF_RES:    rdata = result;
            OFF_RES_HI: rdata = result_hi;
            default:    rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_periph.sv
// Self-checking bench for mul_periph: cycle model of the register map plus directed runs.
module tb_mul_periph;

   localparam logic [15:0] BASE = 16'h6100;
`ifdef MUL_PERIPH_HI_EN
   localparam int LAT   = 17;
   localparam bit HI_EN = 1'b1;
`else
   localparam int LAT   = 16;
   localparam bit HI_EN = 1'b0;
`endif

   logic        clk     = 1'b0;
   logic        reset_n = 1'b1;
   logic [15:0] addrM   = '0;
   logic [15:0] outM    = '0;
   logic        writeM  = 1'b0;
   logic [15:0] rdata;
   logic        sel;
   logic        irq;

   int checks = 0;
   int errors = 0;

   mul_periph #(.BASE_ADDR(BASE), .W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .addrM   (addrM),
      .outM    (outM),
      .writeM  (writeM),
      .rdata   (rdata),
      .sel     (sel),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // Behavioural model: registers, a latency countdown and the arithmetic product.
   logic [15:0] m_opa = '0, m_opb = '0, m_res = '0, m_res_hi = '0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_irq = 1'b0;
   int          m_cnt = 0;
   int          m_prod = 0;
   logic        m_hit;
   logic [15:0] m_off;

   function automatic bit in_win(input logic [15:0] a);
      return (a >= BASE) && (a <= BASE + 16'd7);
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] a);
      if (!in_win(a)) return 16'h0;
      case (a - BASE)
         16'd0:   return m_opa;
         16'd1:   return m_opb;
         16'd2:   return {14'd0, m_done, m_busy};
         16'd3:   return m_res;
         16'd4:   return HI_EN ? m_res_hi : 16'h0;
         default: return 16'h0;
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_opa = '0; m_opb = '0; m_res = '0; m_res_hi = '0;
         m_busy = 1'b0; m_done = 1'b0; m_irq = 1'b0; m_cnt = 0;
      end else begin
         m_hit = writeM && in_win(addrM);
         m_off = addrM - BASE;
         m_irq = m_done;
         if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_busy   = 1'b0;
               m_done   = 1'b1;
               m_res    = m_prod[15:0];
               m_res_hi = m_prod[31:16];
            end
         end else if (m_hit && m_off == 16'd2 && outM[0]) begin
            m_prod = int'($signed(m_opa)) * int'($signed(m_opb));
            m_busy = 1'b1;
            m_done = 1'b0;
            m_cnt  = LAT;
         end else if (m_hit && m_off == 16'd2 && outM[1]) begin
            m_done = 1'b0;
         end
         if (m_hit && m_off == 16'd0) m_opa = outM;
         if (m_hit && m_off == 16'd1) m_opb = outM;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc_irq", {31'd0, irq}, {31'd0, m_irq});
      chk("cyc_sel", {31'd0, sel}, {31'd0, in_win(addrM)});
      chk("cyc_rdata", {16'd0, rdata}, {16'd0, model_read(addrM)});
   end

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      addrM = a; outM = d; writeM = 1'b1;
   endtask

   task automatic peek(input logic [15:0] a, output logic [15:0] d);
      @(posedge clk); #1;
      addrM = a; writeM = 1'b0;
      #1 d = rdata;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
      logic [15:0] d;
      peek(a, d);
      chk(name, {16'd0, d}, {16'd0, exp});
   endtask

   // Counts status reads showing busy; returns the first non-busy status.
   task automatic poll(output int n, output logic [15:0] s);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         peek(BASE + 16'd2, s);
         if (s[0]) n++;
         else break;
      end
   endtask

   task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] lo,
                      input logic [15:0] hi, input bit chk_irq, input string name);
      int n;
      logic [15:0] s;
      wr(BASE, a);
      wr(BASE + 16'd1, b);
      wr(BASE + 16'd2, 16'h0001);
      peek(BASE + 16'd2, s);
      chk({name, "_start_status"}, {16'd0, s}, 32'h1);
      poll(n, s);
      chk({name, "_busy_cycles"}, n + 1, LAT);
      chk({name, "_done_status"}, {16'd0, s}, 32'h2);
      if (chk_irq) begin
         chk({name, "_irq_lag"}, {31'd0, irq}, 32'd0);
         @(posedge clk); #1;
         chk({name, "_irq_rise"}, {31'd0, irq}, 32'd1);
      end
      rd(BASE + 16'd3, lo, {name, "_result"});
      rd(BASE + 16'd4, HI_EN ? hi : 16'h0, {name, "_result_hi"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [15:0] s;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      rd(BASE,          16'h0, "reset_opa");
      rd(BASE + 16'd1,  16'h0, "reset_opb");
      rd(BASE + 16'd2,  16'h0, "reset_status");
      rd(BASE + 16'd3,  16'h0, "reset_result");
      chk("reset_irq", {31'd0, irq}, 32'd0);

      run(16'd3,     16'd4,      16'd12,    16'h0000, 1'b1, "3x4");
      run(16'd42,    16'd7,      16'd294,   16'h0000, 1'b0, "42x7");
      run(16'd0,     16'd0,      16'd0,     16'h0000, 1'b0, "0x0");
      run(16'd1,     16'd0,      16'd0,     16'h0000, 1'b0, "1x0");
      run(16'd0,     16'd3,      16'd0,     16'h0000, 1'b0, "0x3");
      run(16'hFFE6,  16'd1,      16'hFFE6,  16'hFFFF, 1'b0, "m26x1");
      run(16'd26,    16'hFFFF,   16'hFFE6,  16'hFFFF, 1'b0, "26xm1");
      run(16'd7,     16'hFFFE,   16'hFFF2,  16'hFFFF, 1'b0, "7xm2");
      run(16'hFFF9,  16'hFFFE,   16'd14,    16'h0000, 1'b0, "m7xm2");
      run(16'd300,   16'd300,    16'h5F90,  16'h0001, 1'b0, "300x300");

      // Operand write and second start while running
      wr(BASE, 16'd3);
      wr(BASE + 16'd1, 16'd4);
      wr(BASE + 16'd2, 16'h0001);
      wr(BASE, 16'd100);
      wr(BASE + 16'd2, 16'h0001);
      poll(n, s);
      chk("midrun_busy_cycles", n, LAT - 2);
      chk("midrun_done_status", {16'd0, s}, 32'h2);
      rd(BASE + 16'd3, 16'd12,  "midrun_result");
      rd(BASE,         16'd100, "midrun_opa");

      // Addresses outside the window, including aliases of OPA and CTRL
      wr(BASE + 16'd8,  16'h0007);
      wr(BASE - 16'd1,  16'h0003);
      wr(BASE + 16'd10, 16'h0001);
      rd(BASE + 16'd8, 16'h0, "out_hi_rdata");
      chk("out_hi_sel", {31'd0, sel}, 32'd0);
      rd(BASE - 16'd1, 16'h0, "out_lo_rdata");
      chk("out_lo_sel", {31'd0, sel}, 32'd0);
      rd(BASE,         16'd100, "out_opa_kept");
      rd(BASE + 16'd2, 16'h2,   "out_status_kept");
      wr(BASE + 16'd5, 16'hFFFF);
      rd(BASE + 16'd5, 16'h0, "off5");
      rd(BASE + 16'd6, 16'h0, "off6");
      rd(BASE + 16'd7, 16'h0, "off7");

      // Reset asserted in the middle of a run
      wr(BASE + 16'd2, 16'h0001);
      peek(BASE + 16'd2, s);
      chk("prereset_busy", {16'd0, s}, 32'h1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1 chk("rst_status", {16'd0, rdata}, 32'h0);
      addrM = BASE + 16'd3;
      #1 chk("rst_result", {16'd0, rdata}, 32'h0);
      addrM = BASE;
      #1 chk("rst_opa", {16'd0, rdata}, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // clear_done, then start+clear together
      run(16'd2, 16'd5, 16'd10, 16'h0000, 1'b0, "2x5");
      wr(BASE + 16'd2, 16'h0002);
      rd(BASE + 16'd2, 16'h0, "clear_done");
      run(16'd6, 16'd7, 16'd42, 16'h0000, 1'b0, "6x7");
      wr(BASE + 16'd2, 16'h0003);
      peek(BASE + 16'd2, s);
      chk("start_and_clear", {16'd0, s}, 32'h1);
      poll(n, s);
      chk("start_and_clear_done", {16'd0, s}, 32'h2);
      rd(BASE + 16'd3, 16'd42, "start_and_clear_result");

      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_periph.md
Name: mul_periph

Overview:
Memory-mapped sequential multiplier on the CPU data bus, downstream of the CPU's addrM/outM/writeM outputs. Its read data is muxed into the CPU's inM. Software writes two operands and a start command, polls status, then reads the product. This offloads the software add-loop multiply to a fixed-latency shift-add engine.

Parameters:
BASE_ADDR, 16'h6100, word address of register 0; must be 8-word aligned.
W, 16, operand/result width; log2(W) counter bits.

Ports:
clk  in  1  system clock, rising-edge.
reset_n  in  1  asynchronous active-low reset.
addrM  in  16  CPU data address.
outM  in  16  CPU write data.
writeM  in  1  CPU write strobe, sampled at posedge clk.
rdata  out  16  read data for addressed register; combinational from addrM; 0 when not selected.
sel  out  1  combinational, high when addrM is in [BASE_ADDR, BASE_ADDR+7]; the system inM mux uses it.
irq  out  1  registered copy of the done flag.

Behaviour:
- Register map (offsets):
  - 0 OPA: RW.
  - 1 OPB: RW.
  - 2 CTRL/STATUS:
    - write: bit0 = start, bit1 = clear_done.
    - read: bit0 = busy, bit1 = done, others 0.
  - 3 RESULT: RO, low W bits of signed product.
  - 4 RESULT_HI: only with the optional feature.
  - 5-7: read 0, writes ignored.
- Reads have no side effects; polling is safe at any rate.
- Reset values: OPA = OPB = RESULT = 0, busy = done = irq = 0, FSM = IDLE, counter = 0. rdata and sel are purely combinational.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE: a write to CTRL with bit0 = 1 at edge k does the following at edge k:
    - latches OPA/OPB into internal multiplicand/multiplier shadows;
    - clears the accumulator, clears done, sets busy;
    - enters RUN with count = 0.
  - RUN: one multiplier bit per cycle (LSB first).
    - If the bit is set: accumulator += multiplicand << count (mod 2^W).
    - Then count++.
    - At count == W-1 (edge k+W): RESULT <= final accumulator, busy = 0, done = 1, enter DONE.
  - Latency: start write at edge k means RESULT is valid and done = 1 after edge k+W (16 cycles at default).
- Arithmetic: two's complement. The low W bits are sign-independent, so an unsigned shift-add gives the correct truncated signed product. Overflow wraps silently.
- Boundary conditions:
  - Start while busy: ignored. The current op continues and the shadows are unchanged.
  - OPA/OPB writes during RUN: update the visible registers only; the in-flight op uses the shadows.
  - RESULT read during RUN: returns the previous result. RESULT updates only at completion.
  - clear_done (bit1) in DONE: done = 0, state returns to IDLE.
  - Same CTRL write with bit0 = 1 and bit1 = 1: start wins; done is cleared as part of start.
  - Writes to any address outside the window are ignored; sel = 0 and rdata = 0 there.
  - reset_n low mid-RUN: immediate return to reset values; the in-flight op is lost.
- irq = done delayed one cycle; cleared with done.

Optional Feature:
MUL_PERIPH_HI_EN
- Defined:
  - Offset 4 RESULT_HI is RO and holds the upper W bits of the full 2W-bit signed product.
  - The engine latches operand magnitudes plus a sign flag and accumulates into 2W bits over W cycles.
  - After the last accumulation it negates the 2W-bit value if the signs differ, which adds one cycle (done after edge k+W+1).
  - Reset value of RESULT_HI is 0.
- Not defined:
  - Offset 4 reads 0; latency is exactly W cycles.
  - RTL contains no 2W-bit accumulator.

Decomposition:
- Package mul_periph_pkg holds:
  - register offset constants OFF_OPA, OFF_OPB, OFF_CTRL, OFF_RES, OFF_RES_HI;
  - CTRL bit indices;
  - FSM state enum (IDLE, RUN, DONE);
  - default W.
- One sub-module, mul_core: shadow registers, accumulator, counter, start/busy/done interface.
- mul_periph holds address decode, the register file and the read mux.

Test Plan:
- OPA=3, OPB=4, start, poll status -> busy=1 for 16 cycles, then done=1 and RESULT=12; irq rises one cycle after done.
- 42*7 -> 294. 0*0 -> 0. 1*0 -> 0. 0*3 -> 0. Each run starts from DONE without clear_done; done must drop at start.
- Signed cases: -26*1 -> -26 (0xFFE6); 26*-1 -> -26; 7*-2 -> -14 (0xFFF2); -7*-2 -> 14. With MUL_PERIPH_HI_EN: RESULT_HI = 0xFFFF for negative products, 0 otherwise.
- Overflow: 300*300 -> RESULT = 0x5F90. With MUL_PERIPH_HI_EN: RESULT_HI = 0x0001.
- During RUN of 3*4: write OPA=100 and issue a second start. Required: RESULT=12, OPA reads 100, busy timing unchanged. Then assert reset_n low mid-RUN: all status bits and RESULT become 0 immediately.
- Addresses BASE_ADDR-1 and BASE_ADDR+8: sel=0, rdata=0, writes have no effect. Offsets 5-7 read 0.
